// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with start/ack run control.
// Optional return stack under PC_CALL_STACK_EN.
module pc_sequencer #(
  parameter int PC_W    = 12,
  parameter int LUT_AW  = 4,
  parameter int STACK_D = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchAbs,
  input  logic              BranchRel,
  input  logic              Taken,
  input  logic [LUT_AW-1:0] LutIdx,
  input  logic [PC_W-1:0]   Offset,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutTarget,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
`ifdef PC_CALL_STACK_EN
  input  logic              Call,
  input  logic              Ret,
  output logic              StackErr,
`endif
  output logic              Ack
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  if (STACK_D < 1) begin : g_chk
    $error("STACK_D must be at least 1");
  end

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

`ifdef PC_CALL_STACK_EN
  localparam int SP_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int CN_W = $clog2(STACK_D + 1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_D - 1);
  localparam logic [CN_W-1:0] CN_MAX = CN_W'(STACK_D);

  logic [PC_W-1:0] mem [STACK_D];
  logic [SP_W-1:0] wp_q, wp_inc, wp_dec;
  logic [CN_W-1:0] cnt_q;
  logic            err_q;
  logic            push, pop, clr, err_set;

  // Write pointer wraps so a full push overwrites the oldest entry.
  assign wp_inc = (wp_q == SP_MAX) ? '0 : wp_q + SP_W'(1);
  assign wp_dec = (wp_q == '0) ? SP_MAX : wp_q - SP_W'(1);
  assign StackErr = err_q;
`endif

  assign LutAddr = LutIdx;
  assign PC      = pc_q;
  assign Running = (state_q == RUN);
  assign Ack     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    err_set = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = RUN;
`ifdef PC_CALL_STACK_EN
          clr     = 1'b1;
`endif
        end
      end
      RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = DONE;
`ifdef PC_CALL_STACK_EN
          end else if (Call) begin
            push = 1'b1;
            pc_d = LutTarget;
          end else if (Ret) begin
            if (cnt_q == '0) begin
              pc_d    = pc_q + PC_ONE;
              err_set = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = mem[wp_dec];
            end
`endif
          end else if (BranchAbs && Taken) begin
            pc_d = LutTarget;
          end else if (BranchRel && Taken) begin
            pc_d = pc_q + Offset;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge Clk) begin
    if (push) mem[wp_q] <= pc_q + PC_ONE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (clr) begin
        wp_q  <= '0;
        cnt_q <= '0;
      end
      if (push) begin
        wp_q <= wp_inc;
        if (cnt_q != CN_MAX) cnt_q <= cnt_q + CN_W'(1);
      end
      if (pop) begin
        wp_q  <= wp_dec;
        cnt_q <= cnt_q - CN_W'(1);
      end
      if (err_set) err_q <= 1'b1;
    end
  end
`endif

endmodule
